// File: rtl/pool_result_collector.sv
// Collects one OUT_DIM x OUT_DIM frame of signed pooled samples in raster order,
// tracks the running max/argmax, and serves a registered random-access read port.
module pool_result_collector #(
    parameter int OUT_DIM = 7,
    parameter int DW      = 16,
    parameter int AW      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pool_valid,
    input  logic [DW-1:0] pool_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          frame_done,
    output logic [AW-1:0] count,
    output logic [DW-1:0] max_val,
    output logic [AW-1:0] max_idx,
    output logic          overflow
);
    localparam int            DEPTH = OUT_DIM * OUT_DIM;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH);
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_en;
    logic          new_max;

    // start pre-empts any sample arriving in the same cycle
    assign wr_en   = !rst && !start && (state == S_COLLECT) && pool_valid;
    assign new_max = (count == '0) || ($signed(pool_data) > $signed(max_val));

    // Buffer is not reset; kept apart from the reset-bearing control block
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count] <= pool_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            max_val    <= MOST_NEG;
            max_idx    <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            // Reads sample the array before this cycle's write lands
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= (rd_addr < LIMIT) ? mem[rd_addr] : '0;
            end

            if (start) begin
                state      <= S_COLLECT;
                count      <= '0;
                max_val    <= MOST_NEG;
                max_idx    <= '0;
                overflow   <= 1'b0;
                busy       <= 1'b1;
                frame_done <= 1'b0;
            end else begin
                case (state)
                    S_COLLECT: begin
                        if (pool_valid) begin
                            count <= count + 1'b1;
                            if (new_max) begin
                                max_val <= pool_data;
                                max_idx <= count;
                            end
                            if (count == LAST) begin
                                state      <= S_DONE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (pool_valid) begin
                            overflow <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pool_result_collector.sv
// Self-checking bench for pool_result_collector against an array-based frame model.
module tb_pool_result_collector;
    localparam int N = 49;

    logic        clk = 1'b0;
    logic        rst, start, pool_valid, rd_en;
    logic [15:0] pool_data;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data, max_val;
    logic        rd_valid, busy, frame_done, overflow;
    logic [5:0]  count, max_idx;

    pool_result_collector #(.OUT_DIM(7), .DW(16), .AW(6)) dut (
        .clk(clk), .rst(rst), .start(start), .pool_valid(pool_valid),
        .pool_data(pool_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .frame_done(frame_done), .count(count), .max_val(max_val),
        .max_idx(max_idx), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: frame buffer, captured count, phase (0 idle, 1 collecting, 2 done)
    logic [15:0] m_mem [N];
    int          m_cnt   = 0;
    int          m_phase = 0;
    bit          m_ovf   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Max over captured samples, then the earliest index holding it
    task automatic ref_max(output logic [15:0] v, output int idx);
        int best;
        best = -32768;
        idx  = 0;
        for (int i = 0; i < m_cnt; i++)
            if ($signed(m_mem[i]) > best) best = $signed(m_mem[i]);
        for (int i = m_cnt - 1; i >= 0; i--)
            if ($signed(m_mem[i]) == best) idx = i;
        v = 16'(best);
    endtask

    task automatic model_sample(input logic [15:0] d);
        if (m_phase == 1) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            if (m_cnt == N) m_phase = 2;
        end else if (m_phase == 2) begin
            m_ovf = 1;
        end
    endtask

    task automatic send(input logic [15:0] d);
        pool_valid = 1'b1;
        pool_data  = d;
        tick();
        pool_valid = 1'b0;
        model_sample(d);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start   = 1'b0;
        m_cnt   = 0;
        m_ovf   = 0;
        m_phase = 1;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [15:0] got, output logic v);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        got   = rd_data;
        v     = rd_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        m_phase = 0; m_cnt = 0; m_ovf = 0;
        checks++; if (count !== 6'd0)        begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (frame_done !== 1'b0)   begin errors++; $display("FAIL rst_done got %b exp 0", frame_done); end
        checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        checks++; if (max_val !== 16'h8000)  begin errors++; $display("FAIL rst_max got %h exp 8000", max_val); end
        checks++; if (rd_valid !== 1'b0)     begin errors++; $display("FAIL rst_rdv got %b exp 0", rd_valid); end
        for (int i = 0; i < 3; i++) send(16'(i + 7));
        checks++; if (count !== 6'd0)        begin errors++; $display("FAIL idle_count got %0d exp 0", count); end
        checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL idle_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_ascending;
        logic [15:0] ev, got; int ei; logic v;
        logic [5:0] addrs [3];
        addrs = '{6'd0, 6'd17, 6'd48};
        do_start();
        for (int i = 0; i < N; i++) begin
            checks++; if (frame_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL asc_busy@%0d got busy=%b done=%b exp 1/0", i, busy, frame_done); end
            send(16'(i));
        end
        ref_max(ev, ei);
        checks++; if (busy !== 1'b0 || frame_done !== 1'b1) begin errors++; $display("FAIL asc_done got busy=%b done=%b exp 0/1", busy, frame_done); end
        checks++; if (count !== 6'(m_cnt)) begin errors++; $display("FAIL asc_count got %0d exp %0d", count, m_cnt); end
        checks++; if (max_val !== ev || max_idx !== 6'(ei)) begin errors++; $display("FAIL asc_max got %0d@%0d exp %0d@%0d", max_val, max_idx, ev, ei); end
        foreach (addrs[k]) begin
            do_read(addrs[k], got, v);
            checks++; if (got !== m_mem[addrs[k]] || v !== 1'b1) begin errors++; $display("FAIL asc_read@%0d got %0d v=%b exp %0d v=1", addrs[k], got, v, m_mem[addrs[k]]); end
        end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL asc_rdv_idle got %b exp 0", rd_valid); end
        do_read(6'd55, got, v);
        checks++; if (got !== 16'd0 || v !== 1'b1) begin errors++; $display("FAIL oob_read got %0d v=%b exp 0 v=1", got, v); end
    endtask

    task automatic test_signed_max;
        logic [15:0] ev, d; int ei;
        do_start();
        for (int i = 0; i < N; i++) begin
            d = (i == 0) ? -16'sd5 : (i == 10 || i == 20) ? 16'd300 : (i == 48) ? 16'h8000 : 16'hFFFF;
            send(d);
            if (i < N - 1) begin
                repeat (3) tick();
                checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL gap_early_done@%0d got 1 exp 0", i); end
            end
        end
        ref_max(ev, ei);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL gap_done got %b exp 1", frame_done); end
        checks++; if (max_val !== ev || max_idx !== 6'(ei)) begin errors++; $display("FAIL gap_max got %0d@%0d exp %0d@%0d", $signed(max_val), max_idx, $signed(ev), ei); end
    endtask

    task automatic test_overflow_restart;
        logic [15:0] got; logic v;
        send(16'h1234);
        send(16'h4321);
        checks++; if (overflow !== 1'(m_ovf)) begin errors++; $display("FAIL ovf_set got %b exp %b", overflow, m_ovf); end
        checks++; if (count !== 6'(m_cnt)) begin errors++; $display("FAIL ovf_count got %0d exp %0d", count, m_cnt); end
        do_read(6'd48, got, v);
        checks++; if (got !== m_mem[48]) begin errors++; $display("FAIL ovf_buf got %h exp %h", got, m_mem[48]); end
        do_start();
        checks++; if (overflow !== 1'b0 || count !== 6'd0 || busy !== 1'b1) begin errors++; $display("FAIL restart got ovf=%b cnt=%0d busy=%b exp 0/0/1", overflow, count, busy); end
        checks++; if (max_val !== 16'h8000 || frame_done !== 1'b0) begin errors++; $display("FAIL restart_max got %h done=%b exp 8000/0", max_val, frame_done); end
    endtask

    task automatic test_simultaneous;
        logic [15:0] old, nw, got; logic v;
        for (int i = 0; i < N - 1; i++) send(16'($urandom));
        start = 1'b1; pool_valid = 1'b1; pool_data = 16'h7777;
        tick();
        start = 1'b0; pool_valid = 1'b0;
        m_cnt = 0; m_ovf = 0; m_phase = 1;
        checks++; if (count !== 6'd0 || busy !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL sim_start got cnt=%0d busy=%b done=%b exp 0/1/0", count, busy, frame_done); end
        for (int i = 0; i < 5; i++) send(16'($urandom));
        old = m_mem[5];
        nw  = ~old;
        rd_en = 1'b1; rd_addr = 6'd5; pool_valid = 1'b1; pool_data = nw;
        tick();
        rd_en = 1'b0; pool_valid = 1'b0;
        model_sample(nw);
        checks++; if (rd_data !== old || rd_valid !== 1'b1) begin errors++; $display("FAIL rbw got %h v=%b exp %h v=1", rd_data, rd_valid, old); end
        do_read(6'd5, got, v);
        checks++; if (got !== nw) begin errors++; $display("FAIL rbw_after got %h exp %h", got, nw); end
        checks++; if (count !== 6'(m_cnt)) begin errors++; $display("FAIL rbw_count got %0d exp %0d", count, m_cnt); end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] ev, got; int ei; logic v; logic [5:0] a;
        do_start();
        for (int i = 0; i < 20; i++) begin
            send(16'($urandom));
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_done@%0d got 1 exp 0", i); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_phase = 0; m_cnt = 0; m_ovf = 0;
        checks++; if (count !== 6'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst got cnt=%0d busy=%b done=%b exp 0/0/0", count, busy, frame_done); end
        send(16'h0101);
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL mid_idle got %0d exp 0", count); end
        do_start();
        for (int i = 0; i < N; i++) begin
            send(16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        ref_max(ev, ei);
        checks++; if (frame_done !== 1'b1 || count !== 6'(m_cnt)) begin errors++; $display("FAIL rnd_done got done=%b cnt=%0d exp 1/%0d", frame_done, count, m_cnt); end
        checks++; if (max_val !== ev || max_idx !== 6'(ei)) begin errors++; $display("FAIL rnd_max got %h@%0d exp %h@%0d", max_val, max_idx, ev, ei); end
        for (int k = 0; k < 6; k++) begin
            a = 6'($urandom_range(0, 63));
            do_read(a, got, v);
            checks++; if (got !== ((a < N) ? m_mem[a] : 16'd0) || v !== 1'b1) begin errors++; $display("FAIL rnd_read@%0d got %h v=%b", a, got, v); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pool_valid = 1'b0; pool_data = '0; rd_en = 1'b0; rd_addr = '0;
        test_reset();
        test_ascending();
        test_signed_max();
        test_overflow_restart();
        test_simultaneous();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
